// File: rtl/mux_rr_reg.sv
// N-channel registered mux: explicit select, fixed priority or round-robin.
// Latency: 1 cycle from input transfer to out_valid; sustains 1 word/cycle.
// Backpressure: in_ready only to the granted channel, and only when the output register can load.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   mode, sel         00 explicit (sel), 01 fixed priority, 10/11 round-robin
//   in_valid/in_ready per-channel handshake; in_ready is combinational
//   in_data           packed, channel i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready, out_data, out_sel  registered output stage
module mux_rr_reg #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    localparam int CW    = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic [CW-1:0]           sel,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CW-1:0]           out_sel,
    input  logic                    out_ready
);

    logic [CW-1:0]     ptr;
    logic [NUM_CH-1:0] grant;
    logic              found;
    int                rr_idx;
    logic              any_grant;
    logic [CW-1:0]     gidx;
    logic [WIDTH-1:0]  gdata;
    logic              load;

    // Output register can accept a new word when empty or being drained.
    assign load = ~out_valid | out_ready;

    // One-hot grant. Out-of-range sel codes (non power-of-2 NUM_CH) match
    // no channel, so they simply produce no grant.
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        rr_idx = 0;
        case (mode)
            2'b00: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (int'(sel) == i) begin
                        grant[i] = in_valid[i];
                    end
                end
            end
            2'b01: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!found && in_valid[i]) begin
                        grant[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
            default: begin
                // Search ptr, ptr+1, ... with wrap; ptr is always < NUM_CH.
                for (int k = 0; k < NUM_CH; k++) begin
                    rr_idx = int'(ptr) + k;
                    if (rr_idx >= NUM_CH) begin
                        rr_idx = rr_idx - NUM_CH;
                    end
                    if (!found && in_valid[rr_idx]) begin
                        grant[rr_idx] = 1'b1;
                        found         = 1'b1;
                    end
                end
            end
        endcase
    end

    // Encode the grant into an index and pick the matching data word.
    always_comb begin
        gidx      = '0;
        gdata     = '0;
        any_grant = |grant;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                gidx  = CW'(i);
                gdata = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = grant & {NUM_CH{load & ~rst}};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (any_grant) begin
                out_valid <= 1'b1;
                out_data  <= gdata;
                out_sel   <= gidx;
                // Pointer only advances on a round-robin transfer; it is
                // left alone on mode changes so fairness history survives.
                if (mode[1]) begin
                    ptr <= (gidx == CW'(NUM_CH - 1)) ? '0 : gidx + CW'(1);
                end
            end else begin
                // Drain: data and sel keep their last values.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_reg.sv
module tb_mux_rr_reg;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    // Second instance with a non power-of-2 channel count.
    logic [1:0]  m3;
    logic [1:0]  s3;
    logic [2:0]  v3;
    logic [23:0] d3;
    logic [2:0]  rdy3;
    logic        ov3;
    logic [7:0]  od3;
    logic [1:0]  os3;
    logic        r3;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         ch;
        logic [7:0] dat;
    } exp_t;

    exp_t q[$];
    logic [7:0] ch_dat [4];

    mux_rr_reg #(.NUM_CH(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready)
    );

    mux_rr_reg #(.NUM_CH(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst(rst), .mode(m3), .sel(s3),
        .in_valid(v3), .in_data(d3), .in_ready(rdy3),
        .out_valid(ov3), .out_data(od3), .out_sel(os3),
        .out_ready(r3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every word the consumer takes is compared to the scoreboard.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_word: got sel %0d data %0h, expected none at %0t",
                         out_sel, out_data, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_sel", 32'(out_sel), 32'(e.ch));
                chk("out_data", 32'(out_data), 32'(e.dat));
            end
        end
    end

    // One cycle: drive inputs, check ready/valid mid-cycle, and after the edge
    // record the word expected to appear (epush < 0 means no transfer).
    task automatic step(input logic r, input logic [1:0] m, input logic [1:0] s,
                        input logic [3:0] v, input logic ordy,
                        input logic [3:0] erdy, input logic eov, input int epush);
        rst       = r;
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = ordy;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(erdy));
        chk("out_valid", 32'(out_valid), 32'(eov));
        @(posedge clk);
        #1;
        if (epush >= 0) begin
            exp_t e;
            e.ch  = epush;
            e.dat = ch_dat[epush];
            q.push_back(e);
        end
    endtask

    initial begin
        int exp_rr3 [4];
        ch_dat[0] = 8'h10; ch_dat[1] = 8'h20; ch_dat[2] = 8'h30; ch_dat[3] = 8'h40;
        in_data   = 32'h40302010;
        d3        = 24'h332211;
        rst = 1'b1; mode = 2'b10; sel = 2'd0; in_valid = 4'b1111; out_ready = 1'b1;
        m3 = 2'b00; s3 = 2'd0; v3 = 3'b000; r3 = 1'b1;
        @(posedge clk);
        #1;

        // Reset with all channels requesting.
        step(1, 2'b10, 0, 4'b1111, 1, 4'b0000, 0, -1);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_sel", 32'(out_sel), 32'h0);
        step(1, 2'b10, 0, 4'b1111, 1, 4'b0000, 0, -1);

        // Round-robin, all requesting: 0,1,2,3,0,1,2,3.
        step(0, 2'b10, 0, 4'b1111, 1, 4'b0001, 0, 0);
        step(0, 2'b10, 0, 4'b1111, 1, 4'b0010, 1, 1);
        step(0, 2'b10, 0, 4'b1111, 1, 4'b0100, 1, 2);
        step(0, 2'b10, 0, 4'b1111, 1, 4'b1000, 1, 3);
        step(0, 2'b10, 0, 4'b1111, 1, 4'b0001, 1, 0);
        step(0, 2'b10, 0, 4'b1111, 1, 4'b0010, 1, 1);
        step(0, 2'b10, 0, 4'b1111, 1, 4'b0100, 1, 2);
        step(0, 2'b10, 0, 4'b1111, 1, 4'b1000, 1, 3);

        // Backpressure: ch0 loads, then a 3-cycle stall holds it.
        step(0, 2'b10, 0, 4'b1111, 1, 4'b0001, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 2'b10, 0, 4'b1111, 0, 4'b0000, 1, -1);
            chk("stall_sel", 32'(out_sel), 32'd0);
            chk("stall_data", 32'(out_data), 32'h10);
        end
        step(0, 2'b10, 0, 4'b1111, 1, 4'b0010, 1, 1);

        // Sparse requesters: ch3 brings ptr to 0, then 0,3,0,3.
        step(0, 2'b10, 0, 4'b1000, 1, 4'b1000, 1, 3);
        step(0, 2'b10, 0, 4'b1001, 1, 4'b0001, 1, 0);
        step(0, 2'b10, 0, 4'b1001, 1, 4'b1000, 1, 3);
        step(0, 2'b10, 0, 4'b1001, 1, 4'b0001, 1, 0);
        step(0, 2'b10, 0, 4'b1001, 1, 4'b1000, 1, 3);

        // Explicit select.
        step(0, 2'b00, 2, 4'b1111, 1, 4'b0100, 1, 2);
        step(0, 2'b00, 3, 4'b1111, 1, 4'b1000, 1, 3);
        step(0, 2'b00, 2, 4'b1011, 1, 4'b0000, 1, -1);
        step(0, 2'b00, 2, 4'b1011, 1, 4'b0000, 0, -1);
        chk("drain_sel_hold", 32'(out_sel), 32'd3);
        chk("drain_data_hold", 32'(out_data), 32'h40);

        // Fixed priority; these transfers must not move the RR pointer.
        step(0, 2'b01, 0, 4'b1010, 1, 4'b0010, 0, 1);
        step(0, 2'b01, 0, 4'b1000, 1, 4'b1000, 1, 3);
        step(0, 2'b01, 0, 4'b0110, 1, 4'b0010, 1, 1);

        // Back to round-robin (ptr still 0); mode 11 behaves as 10.
        step(0, 2'b10, 0, 4'b1111, 1, 4'b0001, 1, 0);
        step(0, 2'b11, 0, 4'b1111, 1, 4'b0010, 1, 1);

        // Reset mid-stream with a valid word and ptr=2.
        step(1, 2'b10, 0, 4'b1111, 1, 4'b0000, 1, -1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_sel", 32'(out_sel), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'h0);
        step(0, 2'b10, 0, 4'b1111, 1, 4'b0001, 0, 0);
        step(0, 2'b10, 0, 4'b0000, 1, 4'b0000, 1, -1);
        step(0, 2'b10, 0, 4'b0000, 1, 4'b0000, 0, -1);
        chk("queue_empty", 32'(q.size()), 32'd0);

        // NUM_CH=3: unused sel code 3 grants nothing.
        m3 = 2'b00; s3 = 2'd3; v3 = 3'b111;
        @(negedge clk);
        chk("n3_sel3_ready", 32'(rdy3), 32'd0);
        @(posedge clk);
        #1;
        chk("n3_sel3_valid", 32'(ov3), 32'd0);

        // NUM_CH=3 round-robin wraps 0,1,2,0.
        exp_rr3 = '{0, 1, 2, 0};
        m3 = 2'b10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("n3_rr_ready", 32'(rdy3), 32'(1 << exp_rr3[i]));
            @(posedge clk);
            #1;
            chk("n3_rr_sel", 32'(os3), 32'(exp_rr3[i]));
            chk("n3_rr_data", 32'(od3), 32'(8'h11 * (exp_rr3[i] + 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_reg.md
Name: mux_rr_reg

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output and valid/ready handshake on every port.
- Three selection modes:
  - explicit select, which is the direct successor of the 2:1 select mux;
  - fixed priority;
  - round-robin arbitration.
- Used in the datapath wherever several producers share one consumer, e.g. writeback source select and memory-port sharing.
- One pipeline stage, full throughput.

Parameters:
- NUM_CH, 4, number of input channels (>= 2).
- WIDTH, 32, data width in bits (>= 1).
- CW, $clog2(NUM_CH), width of channel index (derived, localparam).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- mode  input  2  selection mode: 00 explicit sel, 01 fixed priority, 10 round-robin, 11 treated as 10.
- sel  input  CW  channel index used in mode 00.
- in_valid  input  NUM_CH  per-channel valid.
- in_data  input  NUM_CH*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_CH  per-channel ready (combinational).
- out_valid  output  1  registered output valid.
- out_data  output  WIDTH  registered output data.
- out_sel  output  CW  index of the channel that produced out_data.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (rst=1 at a rising edge):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0.
  - in_ready is 0 in the cycle rst is high.
- Load enable: load = ~out_valid | out_ready.
- Grant (one-hot, combinational, at most one bit set):
  - Mode 00: grant[sel] = in_valid[sel]. If sel >= NUM_CH, no grant.
  - Mode 01: lowest index i with in_valid[i]=1.
  - Mode 10/11: first i with in_valid[i]=1, searching ptr, ptr+1, …, wrapping modulo NUM_CH.
- Ready: in_ready[i] = grant[i] & load & ~rst. A non-granted channel never sees ready.
- Transfer: channel i transfers when in_valid[i] & in_ready[i]. On that edge:
  - out_data <= in_data[i]
  - out_sel <= i
  - out_valid <= 1
- Drain:
  - If load=1 and there is no grant, out_valid <= 0 and out_data/out_sel hold their values.
  - If out_valid=1 and out_ready=0, all outputs hold and in_ready=0.
- Simultaneous drain and fill (out_valid=1, out_ready=1, grant present): the old word leaves and the new word loads on the same edge, giving 1 word/cycle.
- Latency: exactly 1 cycle from input transfer to out_valid.
- Pointer:
  - Updates only on a transfer in mode 10/11: ptr <= (i == NUM_CH-1) ? 0 : i+1.
  - Holds in modes 00/01 and whenever there is no transfer.
- Mode or sel change: takes effect on the grant of the same cycle. An already-registered word is unaffected. ptr is not cleared on a mode change.
- Reset mid-operation: a pending output word is discarded (out_valid=0), ptr returns to 0, and no transfer occurs on the reset edge.
- Producer obligation: in_data must be held stable while in_valid=1 and not accepted. The block does not check this.
- NUM_CH not a power of 2: unused sel codes yield no grant, and ptr never exceeds NUM_CH-1.

Test Plan (NUM_CH=4, WIDTH=8 unless noted):
- Reset / idle:
  - Stimulus: hold rst=1 for 2 cycles with all in_valid=1111, then release.
  - Response: out_valid=0, out_data=0x00, out_sel=0 and in_ready=0000 during reset; first transfer on the cycle after release.
- Explicit select:
  - Stimulus: mode=00, sel=2, in_valid=1111, data ch0..3 = 0x10, 0x20, 0x30, 0x40, out_ready=1.
  - Response: in_ready=0100 and, next cycle, out_data=0x30, out_sel=2.
  - Then sel=3 → out_data=0x40.
  - Then sel=2 with in_valid[2]=0 → out_valid drops to 0.
- Fixed priority:
  - Stimulus: mode=01, in_valid=1010.
  - Response: grant to ch1, out_sel=1.
  - Then in_valid=1000 → out_sel=3.
- Round-robin fairness:
  - Stimulus: mode=10, in_valid=1111 held, out_ready=1, for 8 cycles.
  - Response: out_sel sequence 0,1,2,3,0,1,2,3 with out_valid=1 every cycle after the first.
  - With in_valid=1001: sequence 0,3,0,3.
- Backpressure:
  - Stimulus: mode=10, stream active, out_ready=0 for 3 cycles, then 1.
  - Response: out_data/out_sel held constant, in_ready=0000 during stall, no word lost or duplicated; sequence resumes at the next pointer position.
- Reset mid-stream / NUM_CH=3:
  - Stimulus: assert rst with out_valid=1 and ptr=2.
  - Response: out_valid=0 and the first post-reset grant goes to ch0.
  - With NUM_CH=3, mode=00, sel=3: in_ready=000 and out_valid=0.
